cell_reveal_engine: RTL and testbench

- Player-side reader of the Minesweeper board. The bomb-placement path writes the board; this block consumes it.
- Takes reveal and flag requests for one cell, and maintains the `revealed` and `flagged` bitmaps that the display path reads.
- Performs a sequential flood-fill (BFS) from zero-adjacency cells.
- Reports loss on a bomb hit and win when every safe cell is revealed.

---
 rtl/minas_pkg.sv | 27 ++
 rtl/reveal_queue.sv | 39 +++
 rtl/cell_reveal_engine.sv | 155 +++++++++++++++
 tb/tb_cell_reveal_engine.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minas_pkg.sv
// Shared board geometry, FSM state encoding and neighbour offsets for the
// Minesweeper player-side logic.
package minas_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int CELLS = ROWS * COLS;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    SCAN = 3'd2,
    LOST = 3'd3,
    WON  = 3'd4
  } state_t;

  // Direction order: NW, N, NE, W, E, SW, S, SE
  typedef logic [2:0] dir_t;

  localparam int DROW [8] = '{-1, -1, -1,  0, 0,  1, 1, 1};
  localparam int DCOL [8] = '{-1,  0,  1, -1, 1, -1, 0, 1};

  function automatic int idx(input int row, input int col, input int ncols = COLS);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/reveal_queue.sv
// Flood-fill work queue: a FIFO of cell indices whose pointers never wrap,
// because each cell is pushed at most once per game.
module reveal_queue #(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [IW-1:0] push_idx,
  input  logic          pop,
  output logic [IW-1:0] head,
  output logic          empty
);

  logic [IW-1:0] mem [DEPTH];
  logic [IW:0]   wr_ptr;
  logic [IW:0]   rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (IW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (IW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are meaningful, so clearing the array would only cost flops.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= push_idx;
  end

  assign head  = mem[rd_ptr[IW-1:0]];
  assign empty = (rd_ptr == wr_ptr);

endmodule

// File: rtl/cell_reveal_engine.sv
// Player request engine: flag/reveal single cells, BFS flood-fill from
// zero-adjacency cells, and sticky win/loss detection.
module cell_reveal_engine #(
  parameter  int ROWS  = minas_pkg::ROWS,
  parameter  int COLS  = minas_pkg::COLS,
  localparam int CELLS = ROWS * COLS,
  localparam int IW    = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CELLS-1:0]   bomb_map,
  input  logic [4*CELLS-1:0] adj_count,
  input  logic [IW:0]        num_bombs,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_flag,
  input  logic [2:0]         req_row,
  input  logic [2:0]         req_col,
  output logic [CELLS-1:0]   revealed,
  output logic [CELLS-1:0]   flagged,
  output logic               busy,
  output logic               hit_bomb,
  output logic               win,
  output logic [IW:0]        revealed_cnt
);

  import minas_pkg::*;

  localparam logic [IW:0] CELLS_W = (IW+1)'(CELLS);

  state_t           state;
  dir_t             dir;
  logic [IW-1:0]    centre;
  logic [CELLS-1:0] queued;

  logic [IW:0]   safe_cells;
  logic [IW:0]   cnt_next;
  logic          req_fire;
  logic [IW-1:0] req_idx;
  logic          req_zero;
  int            c_row, c_col, n_row, n_col;
  logic          nb_in;
  logic [IW-1:0] nb_idx;
  logic          nb_valid;
  logic          nb_zero;
  logic          q_push, q_pop, q_empty;
  logic [IW-1:0] q_push_idx, q_head;

  assign safe_cells = CELLS_W - num_bombs;
  assign cnt_next   = revealed_cnt + (IW+1)'(1);

  // NOTE: every signal in this block is given a value before any branch so
  // that no path leaves one unassigned and a latch is never inferred.
  always_comb begin
    req_fire = (state == IDLE) && req_valid &&
               (int'(req_row) < ROWS) && (int'(req_col) < COLS);
    req_idx  = IW'(idx(int'(req_row), int'(req_col), COLS));
    req_zero = (adj_count[{req_idx, 2'b00} +: 4] == 4'd0);

    c_row    = int'(centre) / COLS;
    c_col    = int'(centre) % COLS;
    n_row    = c_row + DROW[dir];
    n_col    = c_col + DCOL[dir];
    nb_in    = (n_row >= 0) && (n_row < ROWS) && (n_col >= 0) && (n_col < COLS);
    nb_idx   = nb_in ? IW'(idx(n_row, n_col, COLS)) : '0;
    nb_valid = (state == SCAN) && nb_in && !revealed[nb_idx] &&
               !flagged[nb_idx] && !bomb_map[nb_idx];
    nb_zero  = (adj_count[{nb_idx, 2'b00} +: 4] == 4'd0);

    q_push     = 1'b0;
    q_push_idx = req_idx;
    if (req_fire && !req_flag && !revealed[req_idx] && !flagged[req_idx] &&
        !bomb_map[req_idx] && req_zero) begin
      q_push = 1'b1;
    end
    if (nb_valid && nb_zero && !queued[nb_idx]) begin
      q_push     = 1'b1;
      q_push_idx = nb_idx;
    end
    q_pop = (state == POP) && !q_empty;
  end

  reveal_queue #(.DEPTH(CELLS), .IW(IW)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_idx (q_push_idx),
    .pop      (q_pop),
    .head     (q_head),
    .empty    (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dir          <= '0;
      centre       <= '0;
      queued       <= '0;
      revealed     <= '0;
      flagged      <= '0;
      revealed_cnt <= '0;
    end else begin
      if (q_push) queued[q_push_idx] <= 1'b1;
      case (state)
        IDLE: begin
          if (req_fire) begin
            if (req_flag) begin
              if (!revealed[req_idx]) flagged[req_idx] <= !flagged[req_idx];
            end else if (!revealed[req_idx] && !flagged[req_idx]) begin
              revealed[req_idx] <= 1'b1;
              if (bomb_map[req_idx]) begin
                state <= LOST;
              end else begin
                revealed_cnt <= cnt_next;
                if (req_zero)                      state <= POP;
                else if (cnt_next == safe_cells)   state <= WON;
              end
            end
          end
        end
        POP: begin
          if (q_empty) begin
            state <= (revealed_cnt == safe_cells) ? WON : IDLE;
          end else begin
            centre <= q_head;
            dir    <= '0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (nb_valid) begin
            revealed[nb_idx] <= 1'b1;
            revealed_cnt     <= cnt_next;
          end
          dir <= dir + 3'd1;
          if (dir == 3'd7) state <= POP;
        end
        default: ;  // LOST and WON hold everything until reset
      endcase
    end
  end

  // Out-of-bounds directions must never produce a board index.
  always_ff @(posedge clk) begin
    if (!reset && state == SCAN && nb_in) begin
      assert (idx(n_row, n_col, COLS) < CELLS);
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state == POP) || (state == SCAN);
  assign hit_bomb  = (state == LOST);
  assign win       = (state == WON);

endmodule

// File: tb/tb_cell_reveal_engine.sv
// Directed and randomized bench for cell_reveal_engine against a plain
// flood-fill model of the game rules.
module tb_cell_reveal_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  bomb_map;
  logic [255:0] adj_count;
  logic [6:0]   num_bombs;
  logic         req_valid, req_ready, req_flag;
  logic [2:0]   req_row, req_col;
  logic [63:0]  revealed, flagged;
  logic         busy, hit_bomb, win;
  logic [6:0]   revealed_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_bomb [64];
  int m_adj  [64];
  bit m_rev  [64];
  bit m_flag [64];
  bit m_lost, m_won;
  int m_cnt, m_nb, m_pushes;
  int busy_cycles;

  cell_reveal_engine #(.ROWS(8), .COLS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .bomb_map     (bomb_map),
    .adj_count    (adj_count),
    .num_bombs    (num_bombs),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_flag     (req_flag),
    .req_row      (req_row),
    .req_col      (req_col),
    .revealed     (revealed),
    .flagged      (flagged),
    .busy         (busy),
    .hit_bomb     (hit_bomb),
    .win          (win),
    .revealed_cnt (revealed_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_rev();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = m_rev[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_flag();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = m_flag[i];
    return v;
  endfunction

  task automatic set_board(input logic [63:0] bm);
    int a;
    m_nb = 0;
    bomb_map = bm;
    for (int i = 0; i < 64; i++) begin
      m_bomb[i] = bm[i];
      m_nb += int'(bm[i]);
    end
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        a = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < 8 && c+dc >= 0 && c+dc < 8)
              a += int'(bm[(r+dr)*8 + c+dc]);
        m_adj[r*8+c] = a;
        adj_count[(r*8+c)*4 +: 4] = 4'(a);
      end
    end
    num_bombs = 7'(m_nb);
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) begin
      m_rev[i]  = 1'b0;
      m_flag[i] = 1'b0;
    end
    m_lost = 1'b0;
    m_won  = 1'b0;
    m_cnt  = 0;
  endtask

  // Game rules: flag toggles, single reveals, and a BFS over zero cells.
  task automatic model_request(input bit flag, input int r, input int c);
    int q[$];
    bit seen [64];
    int i, ctr, n;
    m_pushes = 0;
    i = r*8 + c;
    if (m_lost || m_won) return;
    if (flag) begin
      if (!m_rev[i]) m_flag[i] = !m_flag[i];
      return;
    end
    if (m_rev[i] || m_flag[i]) return;
    m_rev[i] = 1'b1;
    if (m_bomb[i]) begin
      m_lost = 1'b1;
      return;
    end
    m_cnt++;
    if (m_adj[i] == 0) begin
      for (int k = 0; k < 64; k++) seen[k] = 1'b0;
      q.push_back(i);
      seen[i] = 1'b1;
      m_pushes = 1;
      while (q.size() > 0) begin
        ctr = q.pop_front();
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && ctr/8+dr >= 0 && ctr/8+dr < 8 &&
                ctr%8+dc >= 0 && ctr%8+dc < 8) begin
              n = (ctr/8+dr)*8 + ctr%8+dc;
              if (!m_rev[n] && !m_flag[n] && !m_bomb[n]) begin
                m_rev[n] = 1'b1;
                m_cnt++;
                if (m_adj[n] == 0 && !seen[n]) begin
                  q.push_back(n);
                  seen[n] = 1'b1;
                  m_pushes++;
                end
              end
            end
          end
        end
      end
    end
    if (m_cnt == 64 - m_nb) m_won = 1'b1;
  endtask

  task automatic request(input bit flag, input int r, input int c);
    req_flag  = flag;
    req_row   = 3'(r);
    req_col   = 3'(c);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    model_request(flag, r, c);
  endtask

  task automatic settle();
    busy_cycles = 0;
    while (busy && busy_cycles < 3000) begin
      busy_cycles++;
      @(negedge clk);
    end
    check("settle_busy", 64'(busy), 64'd0);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".revealed"}, revealed, pack_rev());
    check({tag, ".flagged"},  flagged,  pack_flag());
    check({tag, ".cnt"},      64'(revealed_cnt), 64'(m_cnt));
    check({tag, ".hit_bomb"}, 64'(hit_bomb), 64'(m_lost));
    check({tag, ".win"},      64'(win), 64'(m_won));
    check({tag, ".ready"},    64'(req_ready), 64'(!(m_lost || m_won)));
  endtask

  initial begin
    logic [63:0] bm;
    bit          fl;
    int          nb;

    reset = 1'b1; req_valid = 1'b0; req_flag = 1'b0; req_row = '0; req_col = '0;
    set_board(64'd0);
    @(negedge clk);
    do_reset();
    check("rst.revealed", revealed, 64'd0);
    check("rst.flagged",  flagged,  64'd0);
    check("rst.cnt",      64'(revealed_cnt), 64'd0);
    check("rst.busy",     64'(busy), 64'd0);
    check("rst.hit",      64'(hit_bomb), 64'd0);
    check("rst.win",      64'(win), 64'd0);
    check("rst.ready",    64'(req_ready), 64'd1);

    // Non-zero single reveal: (2,3) has two bomb neighbours.
    set_board((64'd1 << 10) | (64'd1 << 12));
    do_reset();
    request(1'b0, 2, 3);
    check("single.revealed", revealed, 64'd1 << 19);
    check("single.cnt",   64'(revealed_cnt), 64'd1);
    check("single.busy",  64'(busy), 64'd0);
    check("single.ready", 64'(req_ready), 64'd1);

    // Full-board flood with one corner bomb.
    set_board(64'd1 << 63);
    do_reset();
    request(1'b0, 0, 0);
    check("fill.busy_start", 64'(busy), 64'd1);
    settle();
    check("fill.busy_cycles", 64'(busy_cycles), 64'd541);
    check("fill.revealed", revealed, 64'h7FFF_FFFF_FFFF_FFFF);
    check("fill.cnt",   64'(revealed_cnt), 64'd63);
    check("fill.win",   64'(win), 64'd1);
    check("fill.ready", 64'(req_ready), 64'd0);
    compare_all("fill");

    // Bomb hit, then ignored requests, then reset.
    set_board(64'd1 << 36);
    do_reset();
    request(1'b0, 4, 4);
    check("lose.hit", 64'(hit_bomb), 64'd1);
    check("lose.revealed", revealed, 64'd1 << 36);
    request(1'b0, 0, 0);
    request(1'b1, 1, 1);
    compare_all("lose.frozen");
    do_reset();
    check("lose.rst.revealed", revealed, 64'd0);
    check("lose.rst.hit", 64'(hit_bomb), 64'd0);
    check("lose.rst.ready", 64'(req_ready), 64'd1);

    // Flag toggling and flags surviving a flood.
    set_board(64'd1 << 63);
    do_reset();
    request(1'b1, 0, 1);
    check("flag.set", flagged, 64'd2);
    request(1'b0, 0, 1);
    check("flag.noop_rev", revealed, 64'd0);
    request(1'b1, 0, 1);
    check("flag.clear", flagged, 64'd0);
    request(1'b0, 0, 0);
    settle();
    check("flag.unflagged_rev", 64'(revealed[1]), 64'd1);
    compare_all("flag.flood1");
    do_reset();
    request(1'b1, 0, 1);
    request(1'b0, 0, 0);
    settle();
    check("flag.held_rev", 64'(revealed[1]), 64'd0);
    check("flag.held_win", 64'(win), 64'd0);
    check("flag.held_cnt", 64'(revealed_cnt), 64'd62);
    compare_all("flag.flood2");

    // Reset in the fifth cycle of a flood.
    do_reset();
    request(1'b0, 0, 0);
    repeat (4) @(negedge clk);
    check("abort.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort.revealed", revealed, 64'd0);
    check("abort.busy",  64'(busy), 64'd0);
    check("abort.ready", 64'(req_ready), 64'd1);
    check("abort.cnt",   64'(revealed_cnt), 64'd0);
    do_reset();

    // Corner flood bounded by a column of bombs.
    bm = '0;
    for (int r = 0; r < 8; r++) bm[r*8+5] = 1'b1;
    set_board(bm);
    do_reset();
    request(1'b0, 0, 7);
    settle();
    check("corner.revealed", revealed, 64'hC0C0_C0C0_C0C0_C0C0);
    check("corner.cnt", 64'(revealed_cnt), 64'd16);
    compare_all("corner");

    // Randomized games against the model.
    for (int g = 0; g < 6; g++) begin
      bm = '0;
      nb = int'($urandom_range(3, 12));
      for (int k = 0; k < nb; k++) bm[$urandom_range(0, 63)] = 1'b1;
      set_board(bm);
      do_reset();
      for (int s = 0; s < 30; s++) begin
        fl = ($urandom_range(0, 3) == 0);
        request(fl, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        settle();
        if (m_pushes > 0) check("rand.busy_cycles", 64'(busy_cycles), 64'(9*m_pushes + 1));
        compare_all("rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
